// File: rtl/single_sum_arbiter.sv
// single_sum_arbiter: round-robin sharing of one single_sum_v reduction tree
// among N_REQ requesters, with ID tagging and a credit-protected result FIFO.
module single_sum_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 10,
    parameter int LATENCY    = $clog2(WIDTH),
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0][31:0] req_vector,
    output logic                              sum_in_valid,
    output logic [WIDTH-1:0][31:0]            sum_vector,
    input  logic                              sum_out_valid,
    input  logic [31:0]                       sum_c,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [$clog2(N_REQ)-1:0]          res_id,
    output logic [31:0]                       res_sum,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding,
    output logic                              tag_err
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH+1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW  = $clog2(LATENCY+2);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand_id;
    logic            grant_found;
    logic            credit_ok;
    logic            handshake;

    logic [LATENCY:0] tag_vld;
    logic [IDW-1:0]   tag_id [0:LATENCY];
    logic             tail_vld;
    logic [IDW-1:0]   tail_id;
    logic [SW-1:0]    settle_cnt;

    logic [IDW+31:0]  fifo_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_wr;
    logic             fifo_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Arbitration: first valid requester after the last grant, gated by credits
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_id = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    assign credit_ok = (outstanding < CW'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        if (grant_found && credit_ok && !rst)
            req_ready[grant_id] = 1'b1;
    end

    assign handshake = |(req_valid & req_ready);

    // Issue stage: register the granted vector and open its tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= IDW'(N_REQ-1);
            sum_in_valid <= 1'b0;
            sum_vector   <= '0;
            tag_vld      <= '0;
        end else begin
            sum_in_valid <= handshake;
            tag_vld[0]   <= handshake;
            for (int s = 1; s <= LATENCY; s++)
                tag_vld[s] <= tag_vld[s-1];
            if (handshake) begin
                rr_ptr     <= grant_id;
                sum_vector <= req_vector[grant_id];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int s = 1; s <= LATENCY; s++)
            tag_id[s] <= tag_id[s-1];
    end

    assign tail_vld = tag_vld[LATENCY];
    assign tail_id  = tag_id[LATENCY];

    // Tree output stage: the tail tag must line up with the tree's valid.
    // Stale tree outputs right after reset are not counted as mismatches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= SW'(LATENCY+1);
            tag_err    <= 1'b0;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
        end else if (sum_out_valid != tail_vld) begin
            tag_err <= 1'b1;
        end
    end

    // Result FIFO stage: show-ahead, writes follow the tail tag only
    assign fifo_wr   = tail_vld;
    assign res_valid = (fifo_cnt != '0);
    assign fifo_pop  = res_valid & res_ready;
    assign {res_id, res_sum} = res_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= {tail_id, sum_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= ptr_next(wr_ptr);
            if (fifo_pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
            case ({handshake, fifo_pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_single_sum_arbiter.sv
// Bench for single_sum_arbiter: behavioural tree model, arbitration/credit
// reference model and a scoreboard on the tagged result stream.
module tb_single_sum_arbiter;
    localparam int N_REQ      = 4;
    localparam int WIDTH      = 10;
    localparam int LATENCY    = $clog2(WIDTH);
    localparam int FIFO_DEPTH = 8;
    localparam int IDW        = $clog2(N_REQ);
    localparam int CW         = $clog2(FIFO_DEPTH+1);

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic [N_REQ-1:0]                  req_valid = '0;
    logic [N_REQ-1:0]                  req_ready;
    logic [N_REQ-1:0][WIDTH-1:0][31:0] req_vector;
    logic                              sum_in_valid;
    logic [WIDTH-1:0][31:0]            sum_vector;
    logic                              sum_out_valid;
    logic [31:0]                       sum_c;
    logic                              res_valid;
    logic                              res_ready = 1'b0;
    logic [IDW-1:0]                    res_id;
    logic [31:0]                       res_sum;
    logic [CW-1:0]                     outstanding;
    logic                              tag_err;

    int checks   = 0;
    int failures = 0;

    int vec_int [N_REQ][WIDTH];
    bit extra_delay = 1'b0;
    bit fault_mode  = 1'b0;
    bit chk_tag     = 1'b1;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    sum;
        bit             dc;
    } exp_t;
    exp_t sbq [$];

    single_sum_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vector(req_vector),
        .sum_in_valid(sum_in_valid), .sum_vector(sum_vector),
        .sum_out_valid(sum_out_valid), .sum_c(sum_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_sum(res_sum),
        .outstanding(outstanding), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Non-negative integers below 2^24 are exact in float32.
    function automatic logic [31:0] int_to_f32(input int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 24; b++)
            if (n[b]) p = b;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int f32_to_int(input logic [31:0] f);
        int e;
        logic [23:0] m;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0 || e > 23) return 0;
        m = {1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] tree_add(input logic [WIDTH-1:0][31:0] v);
        int acc = 0;
        for (int i = 0; i < WIDTH; i++)
            acc += f32_to_int(v[i]);
        return int_to_f32(acc);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < WIDTH; j++)
                req_vector[i][j] = int_to_f32(vec_int[i][j]);
    end

    // Tree model: fixed LATENCY delay, optionally one cycle late; never reset.
    logic [LATENCY:0] tree_vld = '0;
    logic [31:0]      tree_sum [0:LATENCY];
    always @(posedge clk) begin
        tree_vld[0] <= sum_in_valid;
        tree_sum[0] <= tree_add(sum_vector);
        for (int s = 1; s <= LATENCY; s++) begin
            tree_vld[s] <= tree_vld[s-1];
            tree_sum[s] <= tree_sum[s-1];
        end
    end
    assign sum_out_valid = extra_delay ? tree_vld[LATENCY] : tree_vld[LATENCY-1];
    assign sum_c         = extra_delay ? tree_sum[LATENCY] : tree_sum[LATENCY-1];

    // Reference model and scoreboard monitor
    logic [IDW-1:0] m_ptr = IDW'(N_REQ-1);
    int             m_out = 0;

    always @(negedge clk) begin : monitor
        logic [N_REQ-1:0] exp_ready;
        int   cidx;
        int   g;
        bit   found;
        bit   pop;
        int   acc;
        exp_t e;
        if (rst) begin
            sbq.delete();
            m_ptr = IDW'(N_REQ-1);
            m_out = 0;
        end else begin
            exp_ready = '0;
            found = 1'b0;
            g = 0;
            if (m_out < FIFO_DEPTH) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    cidx = (int'(m_ptr) + k) % N_REQ;
                    if (!found && req_valid[cidx]) begin
                        found = 1'b1;
                        g = cidx;
                    end
                end
            end
            if (found) exp_ready[g] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
            end
            checks++;
            if (outstanding !== CW'(m_out)) begin
                failures++;
                $display("FAIL outstanding: got %0d expected %0d at %0t", outstanding, m_out, $time);
            end
            if (chk_tag) begin
                checks++;
                if (tag_err !== 1'b0) begin
                    failures++;
                    $display("FAIL tag_err: got %b expected 0 at %0t", tag_err, $time);
                end
            end
            pop = res_valid && res_ready;
            if (pop) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL result: unexpected id=%0d sum=%h expected none at %0t", res_id, res_sum, $time);
                end else begin
                    e = sbq.pop_front();
                    if (res_id !== e.id || (!e.dc && res_sum !== e.sum)) begin
                        failures++;
                        $display("FAIL result: got id=%0d sum=%h expected id=%0d sum=%h at %0t",
                                 res_id, res_sum, e.id, e.sum, $time);
                    end
                end
            end
            if (found) begin
                acc = 0;
                for (int j = 0; j < WIDTH; j++)
                    acc += vec_int[g][j];
                e.id  = IDW'(g);
                e.sum = int_to_f32(acc);
                e.dc  = fault_mode;
                sbq.push_back(e);
                m_ptr = IDW'(g);
            end
            m_out = m_out + (found ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        res_ready = 1'b1;
        n = 0;
        while ((outstanding != '0 || res_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", (n < 100) ? 1 : 0, 1);
    endtask

    task automatic rand_vectors();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < WIDTH; j++)
                vec_int[i][j] = int'($urandom_range(100));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, gid, prev, first, last, nres, hs;
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < WIDTH; j++)
                vec_int[i][j] = 0;

        // Reset values, with all requesters asking
        req_valid = '1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_sum_in_valid", sum_in_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_sum_vector", |sum_vector, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_sum", res_sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (LATENCY + 2) @(posedge clk);

        // Single request: requester 2, ten times 1.0
        for (int j = 0; j < WIDTH; j++) vec_int[2][j] = 1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        #1 chk("single_grant", req_ready, 4'b0100);
        n = 0;
        do begin
            @(posedge clk); #1;
            req_valid = '0;
            n++;
        end while (!res_valid && n < 20);
        chk("single_latency", n, 6);
        chk("single_res_id", res_id, 2);
        chk("single_res_sum", res_sum, 32'h4120_0000);
        @(posedge clk); #1;
        chk("single_outstanding_back", outstanding, 0);

        // Full contention: consecutive rotating grants, gap-free results
        drain();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < WIDTH; j++)
                vec_int[i][j] = i * 16 + j + 1;
        @(posedge clk); #1;
        req_valid = '1;
        prev = 0; first = -1; last = -1; nres = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (c < 12) begin
                gid = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (req_ready[k]) gid = k;
                if (c > 0) chk("rr_order", gid, (prev + 1) % N_REQ);
                prev = gid;
            end
            if (res_valid) begin
                if (first < 0) first = c;
                last = c;
                nres++;
            end
            @(posedge clk); #1;
            if (c == 11) req_valid = '0;
        end
        chk("contention_results", nres, 12);
        chk("contention_no_gaps", last - first + 1, 12);

        // Credit stall
        drain();
        res_ready = 1'b0;
        rand_vectors();
        @(posedge clk); #1;
        req_valid = 4'b0011;
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (|(req_valid & req_ready)) hs++;
            @(posedge clk); #1;
        end
        chk("stall_handshakes", hs, 8);
        chk("stall_req_ready", req_ready, 0);
        chk("stall_outstanding", outstanding, 8);
        chk("stall_fifo_valid", res_valid, 1);
        res_ready = 1'b1;
        #1 chk("stall_pop_cycle_no_grant", req_ready, 0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        #1 chk("stall_credit_return", |req_ready, 1);
        @(posedge clk); #1;
        req_valid = '0;
        #1 chk("stall_refilled", outstanding, 8);

        // Issue and pop in the same cycle at outstanding=5
        drain();
        res_ready = 1'b0;
        rand_vectors();
        @(posedge clk); #1;
        req_valid = 4'b0001;
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        repeat (10) @(posedge clk);
        #1 chk("simul_before", outstanding, 5);
        req_valid = 4'b0010;
        res_ready = 1'b1;
        #1 chk("simul_grant", req_ready, 4'b0010);
        chk("simul_head_valid", res_valid, 1);
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b0;
        #1 chk("simul_after", outstanding, 5);

        // Reset with three vectors in flight
        drain();
        rand_vectors();
        @(posedge clk); #1;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_sum_in_valid", sum_in_valid, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_sum_vector", |sum_vector, 0);
        chk("midrst_res_id", res_id, 0);
        chk("midrst_res_sum", res_sum, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            #1 chk("midrst_stale_res_valid", res_valid, 0);
            @(posedge clk); #1;
        end
        chk("midrst_tag_err", tag_err, 0);
        req_valid = '1;
        #1 chk("midrst_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;

        // Tree valid one cycle late
        drain();
        chk_tag = 1'b0;
        fault_mode = 1'b1;
        extra_delay = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1 chk("fault_tag_err_set", tag_err, 1);
        repeat (10) @(posedge clk);
        #1 chk("fault_tag_err_sticky", tag_err, 1);
        rst = 1'b1;
        #1 chk("fault_tag_err_cleared", tag_err, 0);
        extra_delay = 1'b0;
        fault_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_tag = 1'b1;

        // Randomized traffic, light then heavy backpressure
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            rand_vectors();
            req_valid = N_REQ'($urandom);
            res_ready = (c < 250) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        end
        drain();
        repeat (2) @(posedge clk);
        #1 chk("scoreboard_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/single_sum_arbiter.md
# single_sum_arbiter

Round-robin controller that shares one `single_sum_v` reduction tree between `N_REQ` requesters. It accepts whole vectors over per-requester valid/ready handshakes and issues at most one vector per cycle into the tree. An ID pipeline tracks each vector through the tree's fixed latency, and tagged sums are returned through a credit-protected result FIFO with backpressure. It sits between the vector producers (dot-product and norm engines) and the shared float32 sum tree.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 10: vector length; must equal the tree's `WIDTH`.
- `LATENCY`, `$clog2(WIDTH)`: tree pipeline depth in cycles; must equal the tree's valid delay.
- `FIFO_DEPTH`, 8: result FIFO entries; also the cap on outstanding vectors.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, [N_REQ]: requester i offers a vector.
- `req_ready`, out, [N_REQ]: one-hot grant; a handshake occurs where valid & ready.
- `req_vector`, in, [31:0] x [N_REQ][WIDTH]: float32 vectors, one per requester.
- `sum_in_valid`, out, 1: registered issue strobe to the tree.
- `sum_vector`, out, [31:0] x [WIDTH]: registered vector to the tree.
- `sum_out_valid`, in, 1: the tree's valid output.
- `sum_c`, in, 32: the tree's sum output.
- `res_valid`, out, 1: FIFO head is valid.
- `res_ready`, in, 1: consumer accepts the head.
- `res_id`, out, `$clog2(N_REQ)`: ID of the requester that owns `res_sum`.
- `res_sum`, out, 32: float32 sum.
- `outstanding`, out, `$clog2(FIFO_DEPTH+1)`: count of issued but not yet popped vectors.
- `tag_err`, out, 1: sticky latency-mismatch flag.

## Operation
- **Arbitration:** `rr_ptr` holds the last granted ID. The grant goes to the first valid requester searching `rr_ptr+1, rr_ptr+2, …` with wrap-around. `rr_ptr` updates only on a handshake.
- **Issue condition:** `req_ready` is nonzero only when `outstanding < FIFO_DEPTH`. `req_ready` is combinational from `req_valid`, `rr_ptr` and the registered `outstanding`. A requester that has dropped valid is never granted.
- **Issue:** on a handshake, `sum_vector <= req_vector[g]`, `sum_in_valid <= 1`, and the tag pipeline stage 0 is loaded with {1, g}. With no handshake, `sum_in_valid <= 0` and `sum_vector` holds its value.
- **Tag pipeline:**
  - `LATENCY+1` registered stages of {valid, id}, aligned with the `sum_in_valid` that enters the tree.
  - When the tail valid is 1, {tail id, `sum_c`} is written to the FIFO.
  - If `sum_out_valid` differs from the tail valid, `tag_err` is set to 1. It is cleared only by `rst`, and the write decision still follows the tail valid.
- **FIFO:**
  - Show-ahead, `FIFO_DEPTH` entries; `res_valid` = not empty.
  - Pop happens on `res_valid & res_ready`.
  - The FIFO cannot overflow, because the credit cap bounds in-flight plus stored entries at `FIFO_DEPTH`.
- **Outstanding counter:**
  - +1 on an issue handshake.
  - −1 on a pop.
  - Issue and pop in the same cycle leave it unchanged.
  - A pop does not free a credit until the following cycle.
- **Arithmetic:** none in this block. Sums are passed through bit-exact.

## Timing
- **Reset values:**
  - Control outputs: `req_ready` 0 while `rst` is high, `sum_in_valid` 0, `res_valid` 0, `outstanding` 0, `tag_err` 0.
  - Data outputs: `sum_vector` all 0, `res_id` 0, `res_sum` 0.
  - Internal: all tag stages invalid, FIFO empty, `rr_ptr = N_REQ-1` so requester 0 wins first.
- **Reset mid-operation:** all in-flight tags and FIFO contents are discarded and the tree's late `sum_out_valid` is ignored. This is the only case where `tag_err` is not raised for a mismatch: it is suppressed for `LATENCY+1` cycles after `rst` deasserts.
- **Latency:**
  - Handshake in cycle t → `sum_in_valid` at t+1 → `sum_out_valid` at t+1+LATENCY → `res_valid` at t+2+LATENCY, when the FIFO was empty.
  - With defaults this is t+6.
- **Throughput:** one vector per cycle while credits remain.

## Test plan
- **Single request:** requester 2 sends 10× 0x3F800000 (1.0) with `res_ready=1` → `req_ready=4'b0100` in the same cycle; `res_valid` at t+6 with `res_id=2` and `res_sum=0x41200000` (10.0); `outstanding` returns to 0.
- **Full contention:** all four requesters held valid, each with a distinct vector → grants 0,1,2,3,0,… on consecutive cycles; results return in the same order with matching `res_id` and no gaps.
- **Credit stall:** `res_ready=0`, requesters 0 and 1 always valid → exactly 8 handshakes, then `req_ready=0`; `outstanding=8`, FIFO holds 8. Raise `res_ready` for one cycle → one pop, and a new grant appears the next cycle.
- **Simultaneous events:** at `outstanding=5`, issue and pop in the same cycle → `outstanding` stays 5 and FIFO order is preserved.
- **Reset mid-flight:** assert `rst` with 3 vectors in flight → all outputs take reset values immediately. After release, no stale `res_valid`, `tag_err` stays 0, and the first grant goes to requester 0.
- **Latency fault:** tree model delays `sum_out_valid` by `LATENCY+1` → `tag_err` goes to 1 and stays 1 until `rst`.
